// File: rtl/clksel_sequencer.sv
// CPU clock-switch initiator: picks fast or host clock per cycle and stalls the CPU until the
// switch is confirmed. Optional switch watchdog enabled by defining CLKSEL_WATCHDOG_EN.
module clksel_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LINGER      = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic hsclk_in,
  input  logic rst,
  input  logic cycle_valid,
  input  logic host_access,
  input  logic force_ls,
  input  logic hsclk_selected,
  input  logic lsclk_selected,
  output logic hsclk_sel,
  output logic cpu_hold,
  output logic on_lsclk,
  output logic switch_err
);

  localparam int unsigned LW = (LINGER > 0) ? $clog2(LINGER + 1) : 1;
  localparam logic [LW-1:0] LingerInit = LW'(LINGER);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1) begin : g_param_check
    $error("clksel_sequencer: SYNC_STAGES must be 2..4 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    StLsRun = 2'd0,
    StToHs  = 2'd1,
    StHsRun = 2'd2,
    StToLs  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   linger_q, linger_d;
  logic            hsclk_sel_q, on_lsclk_q;
  logic [SYNC_STAGES-1:0] hs_chain_q, ls_chain_q;
  logic            hs_sync, ls_sync;
  logic            need_ls, want_hs, pending, wd_timeout;

  // Reset values mirror the clock-switch block's own reset (host clock selected).
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hs_chain_q <= '0;
      ls_chain_q <= '1;
    end else begin
      hs_chain_q <= {hs_chain_q[SYNC_STAGES-2:0], hsclk_selected};
      ls_chain_q <= {ls_chain_q[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  assign hs_sync = hs_chain_q[SYNC_STAGES-1];
  assign ls_sync = ls_chain_q[SYNC_STAGES-1];
  assign need_ls = (cycle_valid & host_access) | force_ls;
  assign want_hs = cycle_valid & ~host_access & ~force_ls;
  assign pending = (state_q == StToHs) || (state_q == StToLs);

  always_comb begin
    state_d  = state_q;
    linger_d = linger_q;
    case (state_q)
      StLsRun: begin
        if (need_ls) linger_d = LingerInit;
        else if (linger_q != '0) linger_d = linger_q - 1'b1;
        if (want_hs && linger_q == '0) state_d = StToHs;
      end
      StToHs: begin
        if (hs_sync && !ls_sync) state_d = StHsRun;
        else if (wd_timeout) state_d = StToLs;
      end
      StHsRun: if (need_ls) state_d = StToLs;
      StToLs:  if (!hs_sync && ls_sync) state_d = StLsRun;
      default: state_d = StLsRun;
    endcase
    if (state_d == StLsRun && state_q != StLsRun) linger_d = LingerInit;
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StLsRun;
      linger_q    <= LingerInit;
      hsclk_sel_q <= 1'b0;
      on_lsclk_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      linger_q    <= linger_d;
      hsclk_sel_q <= (state_d == StToHs) || (state_d == StHsRun);
      on_lsclk_q  <= (state_d == StLsRun);
    end
  end

  // Hold is raised in the deciding RUN cycle so no host cycle ever completes on the fast clock.
  assign cpu_hold = pending
                  || ((state_q == StHsRun) && need_ls)
                  || ((state_q == StLsRun) && want_hs && (linger_q == '0));
  assign hsclk_sel = hsclk_sel_q;
  assign on_lsclk  = on_lsclk_q;

`ifdef CLKSEL_WATCHDOG_EN
  localparam int unsigned WdW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q;

  assign wd_timeout = pending && (wd_q >= WdLast);

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q && (state_d == StToHs || state_d == StToLs)) wd_d = '0;
    else if (pending && !wd_timeout) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_q | wd_timeout;
    end
  end

  assign switch_err = err_q;
`else
  assign wd_timeout = 1'b0;
  assign switch_err = 1'b0;
`endif

endmodule
